// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: operation encodings and FSM states.
package shift_seq_pkg;

  // Operation encodings match the shift register's sel input.
  localparam logic [1:0] OP_SHL = 2'b00;
  localparam logic [1:0] OP_SHR = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE,
    RESP
  } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Command, response and shift-register control signals of the sequencer.
// The slave modport is the sequencer's view; the master modport is the
// view of whatever surrounds it (command source, consumer, shift register).
interface shift_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;

  logic             sr_load;
  logic [1:0]       sr_sel;
  logic [WIDTH-1:0] sr_ip;
  logic [WIDTH-1:0] sr_q;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  logic             busy;

  modport slave (
    input  cmd_valid, cmd_data, cmd_op, cmd_count, sr_q, rsp_ready,
    output cmd_ready, sr_load, sr_sel, sr_ip, rsp_valid, rsp_data, busy
  );

  modport master (
    output cmd_valid, cmd_data, cmd_op, cmd_count, sr_q, rsp_ready,
    input  cmd_ready, sr_load, sr_sel, sr_ip, rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/shift_sequencer_step_counter.sv
// Loadable down-counter for the number of remaining shift steps.
// It never decrements below 1, so a long SHIFT phase cannot wrap.
module step_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_isLast
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;

  // Load the step count, then count down once per shift step, stopping at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (i_dec && (r_cnt > ONE)) begin
      r_cnt <= r_cnt - ONE;
    end
  end

  assign o_isLast = (r_cnt == ONE);

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven controller for an external 4-bit shift register.
// Loads a value, applies one shift/rotate op count times, then returns the
// result. Whenever it is not shifting, it reloads the register with its own
// value so the register (which has no enable) holds still.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input logic              clk,
  input logic              rst_n,
  shift_sequencer_if.slave bus
);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_result;
  logic [1:0]       r_op;
  logic [CNT_W-1:0] r_count;
  logic             w_isLast;

  logic             w_cmdReady;
  logic             w_srLoad;
  logic [1:0]       w_srSel;
  logic [WIDTH-1:0] w_srIp;
  logic             w_rspValid;
  logic             w_busy;

  // Remaining-step counter: primed during LOAD, counted down during SHIFT.
  step_counter #(
    .CNT_W (CNT_W)
  ) u_stepCounter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (r_state == LOAD),
    .i_dec    (r_state == SHIFT),
    .i_value  (r_count),
    .o_isLast (w_isLast)
  );

  // State register; reset aborts any command in flight without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture the command on acceptance and the final register value in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data   <= '0;
      r_op     <= OP_SHL;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      if ((r_state == IDLE) && bus.cmd_valid) begin
        r_data  <= bus.cmd_data;
        r_op    <= bus.cmd_op;
        r_count <= bus.cmd_count;
      end
      if (r_state == DONE) begin
        r_result <= bus.sr_q;
      end
    end
  end

  // Next-state logic; a zero count skips SHIFT so no step is ever applied.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.cmd_valid) w_next = LOAD;
      LOAD:    w_next = (r_count == '0) ? DONE : SHIFT;
      SHIFT:   if (w_isLast) w_next = DONE;
      DONE:    w_next = RESP;
      RESP:    if (bus.rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decoded from state: every state except SHIFT reloads the register.
  always_comb begin
    w_cmdReady = 1'b0;
    w_srLoad   = 1'b1;
    w_srSel    = OP_SHL;
    w_srIp     = r_result;
    w_rspValid = 1'b0;
    w_busy     = 1'b1;
    case (r_state)
      IDLE: begin
        w_cmdReady = 1'b1;
        w_busy     = 1'b0;
      end
      LOAD: begin
        w_srIp = r_data;
      end
      SHIFT: begin
        w_srLoad = 1'b0;
        w_srSel  = r_op;
      end
      DONE: begin
        w_srIp = bus.sr_q;
      end
      RESP: begin
        w_rspValid = 1'b1;
      end
      default: begin
        w_cmdReady = 1'b0;
      end
    endcase
  end

  assign bus.cmd_ready = w_cmdReady;
  assign bus.sr_load   = w_srLoad;
  assign bus.sr_sel    = w_srSel;
  assign bus.sr_ip     = w_srIp;
  assign bus.rsp_valid = w_rspValid;
  assign bus.rsp_data  = r_result;
  assign bus.busy      = w_busy;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer with its shift register attached.
// A transaction-level model predicts, from the cycle count since acceptance,
// what every output and the register contents must be, and is checked each cycle.
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  shift_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  logic [WIDTH-1:0] srQ;
  logic             readyFixed;
  logic             readyRand;
  bit               randomReady;

  assign bus.sr_q      = srQ;
  assign bus.rsp_ready = randomReady ? readyRand : readyFixed;

  shift_sequencer #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // The shift register being sequenced: no enable, shifts whenever load is low.
  always_ff @(posedge clk) begin
    if (bus.sr_load) begin
      srQ <= bus.sr_ip;
    end else begin
      case (bus.sr_sel)
        2'b00:   srQ <= {srQ[2:0], 1'b0};
        2'b01:   srQ <= {1'b0, srQ[3:1]};
        2'b10:   srQ <= {srQ[2:0], srQ[3]};
        default: srQ <= {srQ[0], srQ[3:1]};
      endcase
    end
  end

  int nChecks  = 0;
  int nErrors  = 0;
  int cycleCnt = 0;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Random consumer readiness, used only in the randomized phase.
  always @(negedge clk) readyRand = 1'($urandom_range(0, 1));

  // Result of applying op n times to v, in plain integer arithmetic.
  function automatic logic [3:0] refShift(input logic [3:0] v, input logic [1:0] op, input int n);
    int x;
    x = int'(v);
    for (int i = 0; i < n; i++) begin
      case (op)
        OP_SHL:  x = (x * 2) % 16;
        OP_SHR:  x = x / 2;
        OP_ROL:  x = ((x * 2) % 16) + (x / 8);
        default: x = (x / 2) + ((x % 2) * 8);
      endcase
    end
    return 4'(x);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: mK counts rising edges since the accepting edge.
  // k=0 is the load cycle, k=1..count the shift cycles, k=count+1 the freeze
  // cycle, and from k=count+2 the response is offered until taken.
  bit         mBusy;
  int         mK;
  int         mCount;
  logic [3:0] mData;
  logic [1:0] mOp;
  logic [3:0] mResult;
  logic [3:0] mHeld;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mBusy   <= 1'b0;
      mK      <= 0;
      mHeld   <= 4'h0;
      mResult <= 4'h0;
    end else if (!mBusy) begin
      if (bus.cmd_valid) begin
        mBusy   <= 1'b1;
        mK      <= 0;
        mCount  <= int'(bus.cmd_count);
        mData   <= bus.cmd_data;
        mOp     <= bus.cmd_op;
        mResult <= refShift(bus.cmd_data, bus.cmd_op, int'(bus.cmd_count));
      end
    end else if ((mK >= mCount + 2) && bus.rsp_ready) begin
      mBusy <= 1'b0;
      mHeld <= mResult;
    end else begin
      mK <= mK + 1;
    end
  end

  bit compareOn = 1'b0;
  bit inShift;
  assign inShift = mBusy && (mK >= 1) && (mK <= mCount);

  // Per-cycle comparison of the DUT and attached register against the model.
  always @(negedge clk) begin
    if (compareOn && rst_n) begin
      checkOutput("busy", 32'(bus.busy), 32'(mBusy));
      checkOutput("cmd_ready", 32'(bus.cmd_ready), 32'(!mBusy));
      checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(mBusy && (mK >= mCount + 2)));
      checkOutput("sr_load", 32'(bus.sr_load), 32'(!inShift));
      if (inShift) checkOutput("sr_sel", 32'(bus.sr_sel), 32'(mOp));
      if (!mBusy) begin
        checkOutput("sr_q_idle", 32'(srQ), 32'(mHeld));
        checkOutput("rsp_data_idle", 32'(bus.rsp_data), 32'(mHeld));
      end else if (mK == 0) begin
        checkOutput("sr_q_load", 32'(srQ), 32'(mHeld));
      end else if (mK <= mCount + 1) begin
        checkOutput("sr_q_step", 32'(srQ), 32'(refShift(mData, mOp, mK - 1)));
      end else begin
        checkOutput("sr_q_resp", 32'(srQ), 32'(mResult));
        checkOutput("rsp_data", 32'(bus.rsp_data), 32'(mResult));
      end
    end
  end

  // Wait until the model reports acceptance; 0 on timeout.
  task automatic waitAccept(output bit ok);
    int waited = 0;
    ok = 1'b0;
    while (waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
      if (mBusy && (mK == 0)) begin
        ok = 1'b1;
        return;
      end
    end
    checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  // Wait for rsp_valid at a negedge; 0 on timeout.
  task automatic waitRspValid(output bit ok);
    int waited = 0;
    ok = 1'b0;
    while (waited < 100) begin
      @(negedge clk);
      waited++;
      if (bus.rsp_valid) begin
        ok = 1'b1;
        return;
      end
    end
    checkOutput("rsp_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitModelIdle();
    int waited = 0;
    while (mBusy && (waited < 200)) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (mBusy) checkOutput("handshake_timeout", 32'd0, 32'd1);
  endtask

  // Issue one command and return its response and the cycle (accepting cycle = 0)
  // in which rsp_valid was first seen.
  task automatic applyStimulus(input logic [3:0] data, input logic [1:0] op, input logic [2:0] count,
                               output logic [3:0] result, output int latency);
    bit ok;
    int acceptCnt;
    result  = 4'hx;
    latency = -1;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = data;
    bus.cmd_op    = op;
    bus.cmd_count = count;
    waitAccept(ok);
    bus.cmd_valid = 1'b0;
    if (!ok) return;
    acceptCnt = cycleCnt;
    waitRspValid(ok);
    if (!ok) return;
    latency = cycleCnt - acceptCnt + 1;
    result  = bus.rsp_data;
    waitModelIdle();
  endtask

  // Hard stop if the run ever stalls.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] res;
    logic [3:0] heldData;
    logic [3:0] heldQ;
    logic [3:0] rData;
    logic [1:0] rOp;
    logic [2:0] rCount;
    int         lat;
    bit         ok;

    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.cmd_op    = OP_SHL;
    bus.cmd_count = '0;
    readyFixed    = 1'b1;
    randomReady   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("reset_sr_load", 32'(bus.sr_load), 32'd1);
    checkOutput("reset_sr_ip", 32'(bus.sr_ip), 32'd0);
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset_sr_q", 32'(srQ), 32'd0);
    rst_n     = 1'b1;
    compareOn = 1'b1;
    $display("[TB] reset released");

    // Directed cases with hand-computed expectations
    applyStimulus(4'b1011, OP_ROL, 3'd1, res, lat);
    checkOutput("rol1_data", 32'(res), 32'b0111);
    checkOutput("rol1_latency", 32'(lat), 32'd4);

    applyStimulus(4'b1001, OP_ROR, 3'd3, res, lat);
    checkOutput("ror3_data", 32'(res), 32'b0011);
    checkOutput("ror3_latency", 32'(lat), 32'd6);

    applyStimulus(4'b1111, OP_SHL, 3'd5, res, lat);
    checkOutput("shl5_data", 32'(res), 32'b0000);

    applyStimulus(4'b1010, OP_ROL, 3'd4, res, lat);
    checkOutput("rol4_data", 32'(res), 32'b1010);

    applyStimulus(4'b1010, OP_SHR, 3'd0, res, lat);
    checkOutput("zero_data", 32'(res), 32'b1010);
    checkOutput("zero_latency", 32'(lat), 32'd3);

    applyStimulus(4'b1000, OP_SHR, 3'd7, res, lat);
    checkOutput("shr7_data", 32'(res), 32'b0000);

    applyStimulus(4'b0001, OP_ROR, 3'd7, res, lat);
    checkOutput("ror7_data", 32'(res), 32'b0010);
    checkOutput("ror7_latency", 32'(lat), 32'd10);

    // Backpressure with a second command held valid throughout
    $display("[TB] backpressure and back-to-back");
    readyFixed = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 4'b0110;
    bus.cmd_op    = OP_SHL;
    bus.cmd_count = 3'd2;
    waitAccept(ok);
    bus.cmd_data  = 4'b0101;
    bus.cmd_op    = OP_ROR;
    bus.cmd_count = 3'd1;
    waitRspValid(ok);
    heldData = bus.rsp_data;
    heldQ    = srQ;
    checkOutput("bp_first_data", 32'(heldData), 32'b1000);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_stall_rsp_data", 32'(bus.rsp_data), 32'(heldData));
      checkOutput("bp_stall_sr_q", 32'(srQ), 32'(heldQ));
      checkOutput("bp_stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      checkOutput("bp_stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      @(negedge clk);
    end
    readyFixed = 1'b1;
    @(posedge clk);
    #1;
    readyFixed = 1'b0;
    checkOutput("b2b_idle_after_hs", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("b2b_accepted_busy", 32'(bus.busy), 32'd1);
    checkOutput("b2b_accepted_ready", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_valid = 1'b0;
    readyFixed    = 1'b1;
    waitRspValid(ok);
    checkOutput("b2b_second_data", 32'(bus.rsp_data), 32'b1010);
    waitModelIdle();

    // Reset in the middle of a SHIFT phase
    $display("[TB] reset mid-operation");
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 4'b1101;
    bus.cmd_op    = OP_SHL;
    bus.cmd_count = 3'd7;
    waitAccept(ok);
    bus.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("midrst_sr_load", 32'(bus.sr_load), 32'd1);
    checkOutput("midrst_sr_ip", 32'(bus.sr_ip), 32'd0);
    checkOutput("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("postrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("postrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    end

    // Randomized commands with random consumer backpressure
    $display("[TB] randomized phase");
    randomReady = 1'b1;
    for (int n = 0; n < 40; n++) begin
      rData  = 4'($urandom_range(0, 15));
      rOp    = 2'($urandom_range(0, 3));
      rCount = 3'($urandom_range(0, 7));
      applyStimulus(rData, rOp, rCount, res, lat);
      checkOutput("rand_data", 32'(res), 32'(refShift(rData, rOp, int'(rCount))));
      checkOutput("rand_latency", 32'(lat), 32'(int'(rCount) + 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    randomReady = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Command-driven controller for the 4-bit shift-register datapath (load/sel/ip in, q out).
- Accepts one command per valid/ready handshake: load a value, apply one shift/rotate op N times, return the result over a response handshake.
- The shift register has no enable and shifts on every clock while load=0. When not sequencing, this block holds the register's contents by re-loading its own value every cycle ("hold-by-reload").
- Sits between a CSR/command source and one shift_register instance.

Parameters:
- WIDTH, 4, data width of the shift register.
- CNT_W, 3, width of the repeat count (0..2^CNT_W-1 steps).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_data  input  WIDTH  initial value to load.
- cmd_op  input  2  00 SHL, 01 SHR, 10 ROL, 11 ROR (same encoding as the register's sel).
- cmd_count  input  CNT_W  number of op applications.
- sr_load  output  1  drives shift register load.
- sr_sel  output  2  drives shift register sel.
- sr_ip  output  WIDTH  drives shift register ip.
- sr_q  input  WIDTH  shift register output.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  WIDTH  result.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: rst_n low forces IDLE immediately (asynchronous), including mid-operation. It also clears op_q, cnt_q, data_q and result_q to 0.
  - Outputs while in reset and IDLE: cmd_ready=1, sr_load=1, sr_ip=result_q (0 after reset), sr_sel=00, rsp_valid=0, rsp_data=result_q, busy=0.
  - An in-flight command is dropped with no response.
- FSM states: IDLE, LOAD, SHIFT, DONE, RESP. All outputs are decoded from the state and registers only; there are no combinational input-to-output paths except sr_ip=sr_q in DONE.
- IDLE:
  - Outputs: cmd_ready=1, sr_load=1, sr_ip=result_q.
  - On cmd_valid: latch data/op/count and go to LOAD.
- LOAD (exactly 1 cycle):
  - Outputs: sr_load=1, sr_ip=data_q.
  - Next: if count_q==0 go to DONE, else go to SHIFT with cnt_q=count_q.
- SHIFT:
  - Outputs: sr_load=0, sr_sel=op_q; one register step per cycle. cnt_q decrements each cycle.
  - Leave for DONE in the cycle where cnt_q==1, so exactly count steps are applied.
- DONE (1 cycle):
  - Outputs: sr_load=1, sr_ip=sr_q (freezes the register).
  - Action: result_q<=sr_q; next state RESP.
- RESP:
  - Outputs: rsp_valid=1, rsp_data=result_q, sr_load=1, sr_ip=result_q.
  - On rsp_ready go to IDLE. rsp_data stays stable while stalled.
- Latency: with the accepting edge as cycle 0, rsp_valid first rises in cycle count+3.
- Throughput: a new command is accepted no earlier than the cycle after the response handshake.
- cmd_ready=0 outside IDLE. cmd_valid seen while busy is ignored, not queued; the source holds it.
- Shift semantics:
  - SHL/SHR insert 0. Count ≥ WIDTH yields 0.
  - ROL/ROR by WIDTH returns the original value.
  - Count is unsigned. Maximum 2^CNT_W-1 with no wrap; the decrement stops at 1.
- In DONE, RESP and IDLE the register value never changes, because every cycle reloads the same value.

Decomposition:
- Package shift_seq_pkg holds:
  - op encodings: OP_SHL=2'b00, OP_SHR=2'b01, OP_ROL=2'b10, OP_ROR=2'b11;
  - the state enum: IDLE, LOAD, SHIFT, DONE, RESP.
- The shift register is instantiated by the parent (and by the bench) and is not inside this block.
- Optional sub-module step_counter: loadable down-counter, CNT_W wide, with an is_last flag.

Test Plan:
- Reset mid-op: rst_n low during SHIFT → same cycle busy=0, rsp_valid=0, sr_load=1, sr_ip=0. After release cmd_ready=1, no rsp_valid.
- ROL once: data=1011, op=10, count=1 → rsp_data=0111, rsp_valid in cycle 4 after acceptance.
- ROR three times: data=1001, op=11, count=3 → register 1100, 0110, 0011. rsp_data=0011 in cycle 6.
- Over-shift: data=1111, op=00, count=5 → rsp_data=0000. ROL count=4 on 1010 → 1010.
- Zero count: data=1010, op=01, count=0 → rsp_data=1010, rsp_valid in cycle 3, sr_sel never applied with load=0.
- Backpressure and back-to-back:
  - Stimulus: rsp_ready low for 10 cycles, then high for 1 cycle; a second command held valid throughout.
  - During the stall: rsp_data and sr_q stable, cmd_ready=0.
  - The second command is accepted the cycle after the response handshake, and its result is correct.
